// File: rtl/tdpsram_req_arbiter_if.sv
// Request/response channel between one requester and the dual-port SRAM arbiter.
// The master drives requests and accepts responses; the slave is the arbiter side.
interface tdpsram_req_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 10,
    parameter int NB = 4
);
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [NB-1:0] req_we;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_rdata;

    modport master (
        output req_valid, req_addr, req_we, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/tdpsram_req_arbiter.sv
// Dual-port SRAM front-end: two valid/ready requesters, round-robin serialization of
// same-address collisions, and one response per accepted request with stall buffering.
module tdpsram_req_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_DEPTH = 1024,
    parameter int BYTE_SIZE  = 8,
    localparam int AW = $clog2(DATA_DEPTH),
    localparam int NB = DATA_WIDTH / BYTE_SIZE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tdpsram_req_arbiter_if.slave  a_if,
    tdpsram_req_arbiter_if.slave  b_if,
    output logic [AW-1:0]         addr0_o,
    output logic                  en0_o,
    output logic [NB-1:0]         we0_o,
    output logic [DATA_WIDTH-1:0] wdata0_o,
    input  logic [DATA_WIDTH-1:0] rdata0_i,
    output logic [AW-1:0]         addr1_o,
    output logic                  en1_o,
    output logic [NB-1:0]         we1_o,
    output logic [DATA_WIDTH-1:0] wdata1_o,
    input  logic [DATA_WIDTH-1:0] rdata1_i,
    output logic [15:0]           conflict_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INFL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                state_q    [2];
    state_t                state_d    [2];
    logic [DATA_WIDTH-1:0] hold_q     [2];
    logic [DATA_WIDTH-1:0] hold_d     [2];
    logic [DATA_WIDTH-1:0] rdata      [2];
    logic [DATA_WIDTH-1:0] resp_rdata [2];

    logic [1:0]  req_valid;
    logic [1:0]  resp_ready;
    logic [1:0]  can_acc;
    logic [1:0]  eligible;
    logic [1:0]  req_ready;
    logic [1:0]  accept;
    logic [1:0]  resp_valid;
    logic        addr_eq;
    logic        conflict;
    logic        rr_q;
    logic [15:0] cnt_q;

    assign req_valid  = {b_if.req_valid, a_if.req_valid};
    assign resp_ready = {b_if.resp_ready, a_if.resp_ready};
    assign rdata[0]   = rdata0_i;
    assign rdata[1]   = rdata1_i;

    // A port can take a new request when idle or when its pending response drains now.
    always_comb begin
        can_acc = '0;
        for (int i = 0; i < 2; i++) begin
            can_acc[i] = (state_q[i] == IDLE) | resp_ready[i];
        end
    end

    assign addr_eq  = (a_if.req_addr == b_if.req_addr);
    assign eligible = req_valid & can_acc;
    assign conflict = &eligible & addr_eq;

    // Each side is only held off by an eligible same-address competitor that owns priority,
    // so a side's ready never looks at its own valid.
    assign req_ready[0] = rst_n & can_acc[0] & ~(rr_q & eligible[1] & addr_eq);
    assign req_ready[1] = rst_n & can_acc[1] & ~(~rr_q & eligible[0] & addr_eq);
    assign accept       = req_valid & req_ready;

    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < 2; i++) begin
            state_d[i]    = state_q[i];
            hold_d[i]     = hold_q[i];
            resp_rdata[i] = rdata[i];
            case (state_q[i])
                IDLE: ;
                INFL: begin
                    resp_valid[i] = 1'b1;
                    if (!resp_ready[i]) hold_d[i] = rdata[i];
                end
                HOLD: begin
                    resp_valid[i] = 1'b1;
                    resp_rdata[i] = hold_q[i];
                end
                default: state_d[i] = IDLE;
            endcase
            if (accept[i]) begin
                state_d[i] = INFL;
            end else if (resp_valid[i] && resp_ready[i]) begin
                state_d[i] = IDLE;
            end else if (state_q[i] == INFL) begin
                state_d[i] = HOLD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= IDLE;
                hold_q[i]  <= '0;
            end
            rr_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                hold_q[i]  <= hold_d[i];
            end
            if (conflict) begin
                rr_q <= ~rr_q;
                if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign a_if.req_ready  = req_ready[0];
    assign a_if.resp_valid = resp_valid[0];
    assign a_if.resp_rdata = resp_rdata[0];
    assign b_if.req_ready  = req_ready[1];
    assign b_if.resp_valid = resp_valid[1];
    assign b_if.resp_rdata = resp_rdata[1];

    assign en0_o    = accept[0];
    assign addr0_o  = a_if.req_addr;
    assign we0_o    = accept[0] ? a_if.req_we : '0;
    assign wdata0_o = a_if.req_wdata;
    assign en1_o    = accept[1];
    assign addr1_o  = b_if.req_addr;
    assign we1_o    = accept[1] ? b_if.req_we : '0;
    assign wdata1_o = b_if.req_wdata;

    assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_tdpsram_req_arbiter.sv
// Directed bench for tdpsram_req_arbiter with a write-first dual-port SRAM model.
// Unwritten words read back as 0x10000000 + address.
module tb_tdpsram_req_arbiter;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int NB = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tdpsram_req_arbiter_if #(.DW(DW), .AW(AW), .NB(NB)) a_if ();
    tdpsram_req_arbiter_if #(.DW(DW), .AW(AW), .NB(NB)) b_if ();

    logic [AW-1:0] addr0, addr1;
    logic          en0, en1;
    logic [NB-1:0] we0, we1;
    logic [DW-1:0] wdata0, wdata1;
    logic [DW-1:0] rdata0, rdata1;
    logic [15:0]   ccnt;

    tdpsram_req_arbiter #(.DATA_WIDTH(DW), .DATA_DEPTH(1024), .BYTE_SIZE(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .a_if           (a_if),
        .b_if           (b_if),
        .addr0_o        (addr0),
        .en0_o          (en0),
        .we0_o          (we0),
        .wdata0_o       (wdata0),
        .rdata0_i       (rdata0),
        .addr1_o        (addr1),
        .en1_o          (en1),
        .we1_o          (we1),
        .wdata1_o       (wdata1),
        .rdata1_i       (rdata1),
        .conflict_cnt_o (ccnt)
    );

    // SRAM model: write-first, byte enables, read data one cycle after enable.
    logic [DW-1:0] mem [int];
    logic [DW-1:0] t0, t1;
    always @(posedge clk) begin
        if (en0) begin
            t0 = mem.exists(int'(addr0)) ? mem[int'(addr0)] : 32'h1000_0000 + DW'(addr0);
            for (int k = 0; k < NB; k++) if (we0[k]) t0[8*k +: 8] = wdata0[8*k +: 8];
            mem[int'(addr0)] = t0;
            rdata0 <= t0;
        end else begin
            rdata0 <= 32'hDEAD_BEEF;
        end
        if (en1) begin
            t1 = mem.exists(int'(addr1)) ? mem[int'(addr1)] : 32'h1000_0000 + DW'(addr1);
            for (int k = 0; k < NB; k++) if (we1[k]) t1[8*k +: 8] = wdata1[8*k +: 8];
            mem[int'(addr1)] = t1;
            rdata1 <= t1;
        end else begin
            rdata1 <= 32'hDEAD_BEEF;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_a(input logic v, input logic [AW-1:0] ad, input logic [NB-1:0] we,
                         input logic [DW-1:0] wd);
        a_if.req_valid = v;
        a_if.req_addr  = ad;
        a_if.req_we    = we;
        a_if.req_wdata = wd;
    endtask

    task automatic set_b(input logic v, input logic [AW-1:0] ad, input logic [NB-1:0] we,
                         input logic [DW-1:0] wd);
        b_if.req_valid = v;
        b_if.req_addr  = ad;
        b_if.req_we    = we;
        b_if.req_wdata = wd;
    endtask

    int a_grants;
    int viol;

    initial begin
        rst_n = 1'b0;
        set_a(1'b1, 10'd1, 4'h0, 32'h0);
        set_b(1'b1, 10'd1, 4'h0, 32'h0);
        a_if.resp_ready = 1'b1;
        b_if.resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_a_ready", 32'(a_if.req_ready), 32'd0);
        check("rst_b_ready", 32'(b_if.req_ready), 32'd0);
        check("rst_en0", 32'(en0), 32'd0);
        check("rst_en1", 32'(en1), 32'd0);
        check("rst_a_resp_valid", 32'(a_if.resp_valid), 32'd0);
        check("rst_cnt", 32'(ccnt), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        set_a(1'b0, 10'd0, 4'h0, 32'h0);
        set_b(1'b0, 10'd0, 4'h0, 32'h0);

        // Different addresses in the same cycle: read on A, full write on B.
        @(negedge clk);
        set_a(1'b1, 10'd5, 4'h0, 32'h0);
        set_b(1'b1, 10'd9, 4'hF, 32'hCAFE_F00D);
        #1;
        check("t1_a_ready", 32'(a_if.req_ready), 32'd1);
        check("t1_b_ready", 32'(b_if.req_ready), 32'd1);
        check("t1_en0", 32'(en0), 32'd1);
        check("t1_en1", 32'(en1), 32'd1);
        check("t1_we1", 32'(we1), 32'hF);
        check("t1_we0_read", 32'(we0), 32'h0);
        @(negedge clk);
        set_a(1'b0, 10'd0, 4'h0, 32'h0);
        set_b(1'b1, 10'd9, 4'h3, 32'h1234_5678);
        #1;
        check("t1_a_resp_valid", 32'(a_if.resp_valid), 32'd1);
        check("t1_a_rdata", a_if.resp_rdata, 32'h1000_0005);
        check("t1_b_resp_valid", 32'(b_if.resp_valid), 32'd1);
        check("t1_b_rdata", b_if.resp_rdata, 32'hCAFE_F00D);
        check("t1_en0_idle", 32'(en0), 32'd0);
        check("t1_we0_idle", 32'(we0), 32'h0);
        @(negedge clk);
        set_a(1'b1, 10'd9, 4'h0, 32'h0);
        set_b(1'b0, 10'd0, 4'h0, 32'h0);
        #1;
        check("t1_a_resp_drained", 32'(a_if.resp_valid), 32'd0);
        check("t1_b_partial_rdata", b_if.resp_rdata, 32'hCAFE_5678);
        @(negedge clk);
        set_a(1'b0, 10'd0, 4'h0, 32'h0);
        #1;
        check("t1_a_readback", a_if.resp_rdata, 32'hCAFE_5678);

        // Same-address collision: A wins first, B next; one conflict counted.
        @(negedge clk);
        set_a(1'b1, 10'd3, 4'h0, 32'h0);
        set_b(1'b1, 10'd3, 4'h0, 32'h0);
        #1;
        check("t2_c0_a_ready", 32'(a_if.req_ready), 32'd1);
        check("t2_c0_b_ready", 32'(b_if.req_ready), 32'd0);
        check("t2_c0_en0", 32'(en0), 32'd1);
        check("t2_c0_en1", 32'(en1), 32'd0);
        @(negedge clk);
        set_a(1'b0, 10'd0, 4'h0, 32'h0);
        #1;
        check("t2_c1_b_ready", 32'(b_if.req_ready), 32'd1);
        check("t2_c1_en1", 32'(en1), 32'd1);
        check("t2_c1_en0", 32'(en0), 32'd0);
        check("t2_c1_a_rdata", a_if.resp_rdata, 32'h1000_0003);
        @(negedge clk);
        set_b(1'b0, 10'd0, 4'h0, 32'h0);
        #1;
        check("t2_b_rdata", b_if.resp_rdata, 32'h1000_0003);
        check("t2_cnt", 32'(ccnt), 32'd1);

        // Response stall on A: three cycles of back-pressure, then drain plus new accept.
        @(negedge clk);
        set_a(1'b1, 10'd7, 4'h0, 32'h0);
        #1;
        check("t3_accept", 32'(en0), 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            set_a(1'b1, 10'd8, 4'h0, 32'h0);
            a_if.resp_ready = 1'b0;
            #1;
            check("t3_stall_valid", 32'(a_if.resp_valid), 32'd1);
            check("t3_stall_rdata", a_if.resp_rdata, 32'h1000_0007);
            check("t3_stall_ready", 32'(a_if.req_ready), 32'd0);
            check("t3_stall_en0", 32'(en0), 32'd0);
        end
        @(negedge clk);
        a_if.resp_ready = 1'b1;
        #1;
        check("t3_drain_rdata", a_if.resp_rdata, 32'h1000_0007);
        check("t3_drain_ready", 32'(a_if.req_ready), 32'd1);
        check("t3_drain_en0", 32'(en0), 32'd1);
        check("t3_drain_addr0", 32'(addr0), 32'd8);
        @(negedge clk);
        set_a(1'b0, 10'd0, 4'h0, 32'h0);
        #1;
        check("t3_next_valid", 32'(a_if.resp_valid), 32'd1);
        check("t3_next_rdata", a_if.resp_rdata, 32'h1000_0008);

        // Streaming eight reads on A at full rate.
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i < 8) set_a(1'b1, AW'(16 + i), 4'h0, 32'h0);
            else       set_a(1'b0, 10'd0, 4'h0, 32'h0);
            #1;
            if (i < 8) check("t4_ready", 32'(a_if.req_ready), 32'd1);
            if (i > 0) begin
                check("t4_resp_valid", 32'(a_if.resp_valid), 32'd1);
                check("t4_rdata", a_if.resp_rdata, 32'h1000_0010 + 32'(i - 1));
            end
        end

        // Asynchronous reset while a response is in flight.
        @(negedge clk);
        set_a(1'b1, 10'd2, 4'h0, 32'h0);
        @(negedge clk);
        set_a(1'b0, 10'd0, 4'h0, 32'h0);
        #1;
        check("t5_infl_valid", 32'(a_if.resp_valid), 32'd1);
        set_a(1'b1, 10'd2, 4'h0, 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_rst_resp_valid", 32'(a_if.resp_valid), 32'd0);
        check("t5_rst_ready", 32'(a_if.req_ready), 32'd0);
        check("t5_rst_en0", 32'(en0), 32'd0);
        check("t5_rst_cnt", 32'(ccnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set_a(1'b0, 10'd0, 4'h0, 32'h0);
        @(negedge clk);
        #1;
        check("t5_idle_resp_valid", 32'(a_if.resp_valid), 32'd0);
        check("t5_idle_ready", 32'(a_if.req_ready), 32'd1);

        // Sustained collisions: counter saturates, grants alternate, never a dual same-address enable.
        a_grants = 0;
        viol = 0;
        for (int i = 0; i < 70000; i++) begin
            @(negedge clk);
            set_a(1'b1, 10'd4, 4'h0, 32'h0);
            set_b(1'b1, 10'd4, 4'h0, 32'h0);
            #1;
            if (en0 && en1 && addr0 == addr1) viol++;
            if (en0) a_grants++;
            if (i == 65534) check("t6_cnt_fffe", 32'(ccnt), 32'h0000_FFFE);
            if (i == 65535) check("t6_cnt_ffff", 32'(ccnt), 32'h0000_FFFF);
        end
        @(negedge clk);
        set_a(1'b0, 10'd0, 4'h0, 32'h0);
        set_b(1'b0, 10'd0, 4'h0, 32'h0);
        #1;
        check("t6_cnt_sat", 32'(ccnt), 32'h0000_FFFF);
        check("t6_no_dual_en", 32'(viol), 32'd0);
        check("t6_a_grants", 32'(a_grants), 32'd35000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
